// File: rtl/keynsham_irq_ctrl.sv
// Interrupt controller: latches, masks and prioritises up to 32 sources and raises one CPU request.
// Word-addressed bus slave with registered single-cycle ack/error responses.
module keynsham_irq_ctrl #(
  parameter logic [31:0] bus_address = 32'h0,
  parameter logic [31:0] bus_size    = 32'h0,
  parameter int unsigned nr_irqs     = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               bus_access,
  output logic               bus_cs,
  input  logic [29:0]        bus_addr,
  input  logic [31:0]        bus_wr_val,
  input  logic               bus_wr_en,
  input  logic [3:0]         bus_bytesel,
  output logic               bus_error,
  output logic               bus_ack,
  output logic [31:0]        bus_data,
  input  logic [nr_irqs-1:0] irq_in,
  output logic               irq_req
);

  localparam logic [2:0] OffRaw     = 3'd0;
  localparam logic [2:0] OffEnable  = 3'd1;
  localparam logic [2:0] OffPending = 3'd2;
  localparam logic [2:0] OffType    = 3'd3;
  localparam logic [2:0] OffSwset   = 3'd4;
  localparam logic [2:0] OffActive  = 3'd5;

  logic [nr_irqs-1:0] enable_q, enable_d;
  logic [nr_irqs-1:0] type_q, type_d;
  logic [nr_irqs-1:0] pending_q, pending_d;
  logic [nr_irqs-1:0] prev_q;
  logic [nr_irqs-1:0] wmask, wbits, w1c, swset, type_chg, edge_set, hits;
  logic               irq_req_q, ack_q, error_q;
  logic [31:0]        data_q, rd_data, lane_mask, byte_addr, addr_offs;
  logic [2:0]         offset;
  logic               accepted, wr, unmapped;
  logic               active_valid;
  logic [4:0]         active_idx;

  // Window is [bus_address, bus_address + bus_size) in byte addresses.
  assign byte_addr = {bus_addr, 2'b00};
  assign addr_offs = byte_addr - bus_address;
  assign bus_cs    = (byte_addr >= bus_address) && (addr_offs < bus_size);

  assign offset    = bus_addr[2:0];
  assign accepted  = bus_access & bus_cs;
  assign wr        = accepted & bus_wr_en;
  assign unmapped  = offset[2] & offset[1];
  assign lane_mask = {{8{bus_bytesel[3]}}, {8{bus_bytesel[2]}},
                      {8{bus_bytesel[1]}}, {8{bus_bytesel[0]}}};
  assign wmask     = lane_mask[nr_irqs-1:0];
  assign wbits     = bus_wr_val[nr_irqs-1:0] & wmask;

  logic unused_wr_bits;
  assign unused_wr_bits = ^{bus_wr_val, lane_mask};

  always_comb begin
    enable_d = enable_q;
    type_d   = type_q;
    w1c      = '0;
    swset    = '0;
    if (wr) begin
      unique case (offset)
        OffEnable:  enable_d = (enable_q & ~wmask) | wbits;
        OffType:    type_d   = (type_q & ~wmask) | wbits;
        OffPending: w1c      = wbits;
        OffSwset:   swset    = wbits;
        default: ;
      endcase
    end
    type_chg = type_d ^ type_q;
    edge_set = (irq_in & ~prev_q) | swset;
    // Edge bits: a new set beats W1C; a type change discards stale pending state.
    pending_d = (type_q & (edge_set | (pending_q & ~w1c & ~type_chg))) |
                (~type_q & ~type_chg & irq_in);
  end

  always_comb begin
    hits         = pending_q & enable_q;
    active_valid = 1'b0;
    active_idx   = '0;
    for (int i = int'(nr_irqs) - 1; i >= 0; i--) begin
      if (hits[i]) begin
        active_valid = 1'b1;
        active_idx   = 5'(i);
      end
    end
  end

  always_comb begin
    rd_data = '0;
    case (offset)
      OffRaw:     rd_data = 32'(irq_in);
      OffEnable:  rd_data = 32'(enable_q);
      OffPending: rd_data = 32'(pending_q);
      OffType:    rd_data = 32'(type_q);
      OffActive:  rd_data = {active_valid, 26'b0, active_idx};
      default:    rd_data = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      enable_q  <= '0;
      type_q    <= '0;
      pending_q <= '0;
      prev_q    <= '0;
      irq_req_q <= 1'b0;
      ack_q     <= 1'b0;
      error_q   <= 1'b0;
      data_q    <= '0;
    end else begin
      enable_q  <= enable_d;
      type_q    <= type_d;
      pending_q <= pending_d;
      prev_q    <= irq_in;
      irq_req_q <= |(pending_q & enable_q);
      ack_q     <= accepted & ~unmapped;
      error_q   <= accepted & unmapped;
      data_q    <= (accepted & ~unmapped & ~bus_wr_en) ? rd_data : '0;
    end
  end

  assign irq_req   = irq_req_q;
  assign bus_ack   = ack_q;
  assign bus_error = error_q;
  assign bus_data  = data_q;

endmodule

// File: tb/tb_keynsham_irq_ctrl.sv
// Directed bench for keynsham_irq_ctrl: bus responses go through a scoreboard queue,
// interrupt latency is checked cycle by cycle.
module tb_keynsham_irq_ctrl;

  localparam int unsigned NrIrqs = 8;
  localparam logic [29:0] BaseW  = 30'h400;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              bus_access = 1'b0;
  logic              bus_cs;
  logic [29:0]       bus_addr = '0;
  logic [31:0]       bus_wr_val = '0;
  logic              bus_wr_en = 1'b0;
  logic [3:0]        bus_bytesel = 4'hf;
  logic              bus_error, bus_ack;
  logic [31:0]       bus_data;
  logic [NrIrqs-1:0] irq_in = '0;
  logic              irq_req;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        ack;
    logic        err;
    logic [31:0] data;
    string       tag;
  } exp_t;
  exp_t sb[$];

  keynsham_irq_ctrl #(
    .bus_address(32'h0000_1000),
    .bus_size   (32'h20),
    .nr_irqs    (NrIrqs)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus_access (bus_access),
    .bus_cs     (bus_cs),
    .bus_addr   (bus_addr),
    .bus_wr_val (bus_wr_val),
    .bus_wr_en  (bus_wr_en),
    .bus_bytesel(bus_bytesel),
    .bus_error  (bus_error),
    .bus_ack    (bus_ack),
    .bus_data   (bus_data),
    .irq_in     (irq_in),
    .irq_req    (irq_req)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic compare_head();
    exp_t e;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    check({e.tag, ".ack"}, 32'(bus_ack), 32'(e.ack));
    check({e.tag, ".err"}, 32'(bus_error), 32'(e.err));
    check({e.tag, ".data"}, bus_data, e.data);
  endtask

  task automatic access(input logic [2:0] off, input logic wr, input logic [31:0] wval,
                        input logic [3:0] sel, input logic exp_err, input logic [31:0] exp_data,
                        input string tag);
    sb.push_back('{ack: !exp_err, err: exp_err, data: exp_data, tag: tag});
    bus_addr    = BaseW + 30'(off);
    bus_access  = 1'b1;
    bus_wr_en   = wr;
    bus_wr_val  = wval;
    bus_bytesel = sel;
    tick();
    bus_access  = 1'b0;
    bus_wr_en   = 1'b0;
    compare_head();
  endtask

  task automatic rd(input logic [2:0] off, input logic [31:0] exp, input string tag);
    access(off, 1'b0, 32'h0, 4'hf, 1'b0, exp, tag);
  endtask

  task automatic wr(input logic [2:0] off, input logic [31:0] val, input string tag);
    access(off, 1'b1, val, 4'hf, 1'b0, 32'h0, tag);
  endtask

  initial begin
    // Reset state
    #2;
    check("rst_irq_req", 32'(irq_req), 32'd0);
    check("rst_ack", 32'(bus_ack), 32'd0);
    tick();
    rst = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) rd(3'(i), 32'h0, $sformatf("reset_rd%0d", i));
    check("reset_irq_req", 32'(irq_req), 32'd0);
    tick();
    check("ack_one_cycle", 32'(bus_ack), 32'd0);

    // Edge source 0
    wr(3'd3, 32'h1, "wr_type");
    wr(3'd1, 32'h1, "wr_enable");
    irq_in = 8'h01;
    tick();
    check("edge_req_n1", 32'(irq_req), 32'd0);
    irq_in = 8'h00;
    tick();
    check("edge_req_n2", 32'(irq_req), 32'd1);
    rd(3'd2, 32'h1, "edge_pending");
    rd(3'd5, 32'h8000_0000, "edge_active");
    wr(3'd2, 32'h1, "edge_w1c");
    check("w1c_req_n1", 32'(irq_req), 32'd1);
    tick();
    check("w1c_req_n2", 32'(irq_req), 32'd0);

    // Level source 3
    wr(3'd1, 32'h8, "lvl_enable");
    irq_in = 8'h08;
    tick();
    tick();
    check("lvl_req_on", 32'(irq_req), 32'd1);
    wr(3'd2, 32'h8, "lvl_w1c");
    rd(3'd2, 32'h8, "lvl_pending_held");
    irq_in = 8'h00;
    tick();
    check("lvl_req_off_n1", 32'(irq_req), 32'd1);
    tick();
    check("lvl_req_off_n2", 32'(irq_req), 32'd0);
    rd(3'd2, 32'h0, "lvl_pending_clr");

    // Priority between edge sources 2 and 5
    wr(3'd3, 32'h25, "prio_type");
    irq_in = 8'h24;
    tick();
    irq_in = 8'h00;
    tick();
    wr(3'd1, 32'h24, "prio_enable");
    rd(3'd5, 32'h8000_0002, "prio_active2");
    wr(3'd2, 32'h4, "prio_w1c2");
    rd(3'd5, 32'h8000_0005, "prio_active5");
    wr(3'd1, 32'h0, "prio_enable0");
    rd(3'd5, 32'h0, "prio_active_none");
    check("prio_req_masked", 32'(irq_req), 32'd0);
    rd(3'd2, 32'h20, "prio_pending_kept");

    // SWSET: edge bits only, reads back 0
    wr(3'd4, 32'h1, "swset_edge");
    wr(3'd4, 32'h8, "swset_level");
    rd(3'd2, 32'h21, "swset_pending");
    rd(3'd4, 32'h0, "swset_reads0");
    wr(3'd2, 32'h21, "swset_w1c");
    rd(3'd2, 32'h0, "swset_cleared");

    // Edge and W1C on bit 1 in the same cycle
    wr(3'd3, 32'h27, "race_type");
    irq_in = 8'h02;
    wr(3'd2, 32'h2, "race_w1c");
    irq_in = 8'h00;
    rd(3'd2, 32'h2, "race_pending");
    wr(3'd2, 32'h2, "race_w1c2");
    rd(3'd2, 32'h0, "race_cleared");

    // Byte lanes
    wr(3'd1, 32'h0, "lane_clr");
    access(3'd1, 1'b1, 32'hFFFF_FFFF, 4'b0001, 1'b0, 32'h0, "lane0_wr");
    rd(3'd1, 32'hFF, "lane0_rd");
    access(3'd1, 1'b1, 32'h0, 4'b1110, 1'b0, 32'h0, "lane_hi_wr");
    rd(3'd1, 32'hFF, "lane_hi_rd");
    wr(3'd1, 32'h0, "lane_restore");

    // Unmapped offsets and out-of-window address
    access(3'd6, 1'b0, 32'h0, 4'hf, 1'b1, 32'h0, "unmapped6");
    access(3'd7, 1'b1, 32'hFFFF_FFFF, 4'hf, 1'b1, 32'h0, "unmapped7");
    bus_addr   = BaseW + 30'd8;
    bus_access = 1'b1;
    #1;
    check("out_of_window_cs", 32'(bus_cs), 32'd0);
    tick();
    bus_access = 1'b0;
    check("out_of_window_ack", 32'(bus_ack), 32'd0);

    // RAW reflects irq_in
    irq_in = 8'h81;
    rd(3'd0, 32'h81, "raw_rd");
    irq_in = 8'h00;

    // Reset while an access is in flight
    wr(3'd1, 32'h3, "pre_rst_enable");
    rd(3'd1, 32'h3, "pre_rst_rd");
    sb.push_back('{ack: 1'b0, err: 1'b0, data: 32'h0, tag: "rst_inflight"});
    bus_addr   = BaseW + 30'd1;
    bus_access = 1'b1;
    #3;
    rst = 1'b0;
    #1;
    check("rst_async_ack", 32'(bus_ack), 32'd0);
    tick();
    bus_access = 1'b0;
    check("rst_hold_ack", 32'(bus_ack), 32'd0);
    rst = 1'b1;
    tick();
    compare_head();
    tick();
    check("rst_after_ack", 32'(bus_ack), 32'd0);
    check("rst_after_req", 32'(irq_req), 32'd0);
    rd(3'd1, 32'h0, "post_rst_enable");
    rd(3'd3, 32'h0, "post_rst_type");
    rd(3'd2, 32'h0, "post_rst_pending");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
